// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor: one sum bit per clock, LSB first.
// Optional zero flag output when SERIAL_ADDSUB_ZERO_FLAG_EN is defined.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    output logic             overflow,
    output logic             zero
`else
    output logic             overflow
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sa, sb, sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             accept, last, s_bit, c_nxt;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    logic             nz;
`endif

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    assign accept = start && (state != S_RUN);
    assign last   = (state == S_RUN) && (cnt == CW'(WIDTH - 1));
    assign s_bit  = sa[0] ^ sb[0] ^ carry;
    assign c_nxt  = maj(sa[0], sb[0], carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last)  state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
    end

    // Operand capture and per-bit processing; outputs change only on the final bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa        <= '0;
            sb        <= '0;
            sr        <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
            nz        <= 1'b0;
            zero      <= 1'b0;
`endif
        end else if (accept) begin
            sa    <= a;
            sb    <= b ^ {WIDTH{sub}};
            carry <= sub;
            cnt   <= '0;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
            nz    <= 1'b0;
`endif
        end else if (state == S_RUN) begin
            carry <= c_nxt;
            sr    <= {s_bit, sr[WIDTH-1:1]};
            sa    <= {1'b0, sa[WIDTH-1:1]};
            sb    <= {1'b0, sb[WIDTH-1:1]};
            cnt   <= cnt + CW'(1);
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
            nz    <= nz | s_bit;
`endif
            if (last) begin
                // carry still holds the carry into the MSB at this edge
                result    <= {s_bit, sr[WIDTH-1:1]};
                carry_out <= c_nxt;
                overflow  <= carry ^ c_nxt;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
                zero      <= ~(nz | s_bit);
`endif
            end
        end
    end

endmodule
